// File: rtl/proc_pkg.sv
// Shared definitions for the processor control sequencer:
// instruction field layout, opcode values and FSM states.
package proc_pkg;

    localparam int INSTR_W = 10;
    localparam int OP_W    = 4;
    localparam int REG_W   = 3;
    localparam int NREGS   = 8;

    localparam int OP_LSB  = 6;
    localparam int RX_LSB  = 3;
    localparam int RY_LSB  = 0;

    localparam logic [OP_W-1:0] OP_MV  = 4'b0000;
    localparam logic [OP_W-1:0] OP_MVI = 4'b0001;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0011;
    localparam logic [OP_W-1:0] OP_NOT = 4'b0100;
    localparam logic [OP_W-1:0] OP_AND = 4'b0101;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0110;
    localparam logic [OP_W-1:0] OP_XOR = 4'b0111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_T1   = 2'd1,
        S_T2   = 2'd2,
        S_T3   = 2'd3
    } state_e;

    // Two-operand ALU ops: need an A load in T1 before the ALU step.
    function automatic logic is_binary(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-bit binary to 8-bit one-hot decoder.
// Ports: sel_i register index; onehot_o one-hot select, bit n = Rn.
module dec3to8
    import proc_pkg::*;
(
    input  logic [REG_W-1:0] sel_i,
    output logic [NREGS-1:0] onehot_o
);

    always_comb begin
        onehot_o        = '0;
        onehot_o[sel_i] = 1'b1;
    end

endmodule

// File: rtl/proc_sequencer.sv
// Control FSM for a simple bus-based processor: captures an instruction
// and sequences register/ALU enables over up to three steps.
// Ports: clk, resetn (async, active-low), run/instr capture inputs;
// R_in/R_out one-hot register enables, A_in/G_in/G_out ALU enables,
// extern_en external bus drive, alu_func, done and illegal pulses.
module proc_sequencer
    import proc_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               run,
    input  logic [INSTR_W-1:0] instr,
    output logic [NREGS-1:0]   R_in,
    output logic [NREGS-1:0]   R_out,
    output logic               A_in,
    output logic               G_in,
    output logic               G_out,
    output logic               extern_en,
    output logic [OP_W-1:0]    alu_func,
    output logic               done,
    output logic               illegal
);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;

    logic [OP_W-1:0]    op;
    logic [REG_W-1:0]   rx, ry;
    logic [NREGS-1:0]   rx_oh, ry_oh;

    assign op = ir_q[OP_LSB +: OP_W];
    assign rx = ir_q[RX_LSB +: REG_W];
    assign ry = ir_q[RY_LSB +: REG_W];

    dec3to8 u_dec_rx (
        .sel_i    (rx),
        .onehot_o (rx_oh)
    );

    dec3to8 u_dec_ry (
        .sel_i    (ry),
        .onehot_o (ry_oh)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Outputs depend only on state and IR, never on run/instr directly.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        R_in      = '0;
        R_out     = '0;
        A_in      = 1'b0;
        G_in      = 1'b0;
        G_out     = 1'b0;
        extern_en = 1'b0;
        alu_func  = '0;
        done      = 1'b0;
        illegal   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    ir_d    = instr;
                    state_d = S_T1;
                end
            end
            S_T1: begin
                state_d = S_IDLE;
                unique case (op)
                    OP_MV: begin
                        R_out = ry_oh;
                        R_in  = rx_oh;
                        done  = 1'b1;
                    end
                    OP_MVI: begin
                        extern_en = 1'b1;
                        R_in      = rx_oh;
                        done      = 1'b1;
                    end
                    // Unary op goes straight to the ALU step.
                    OP_NOT: begin
                        R_out    = ry_oh;
                        G_in     = 1'b1;
                        alu_func = op;
                        state_d  = S_T3;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        R_out   = rx_oh;
                        A_in    = 1'b1;
                        state_d = S_T2;
                    end
                    default: begin
                        done    = 1'b1;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_T2: begin
                state_d = S_IDLE;
                if (is_binary(op)) begin
                    R_out    = ry_oh;
                    G_in     = 1'b1;
                    alu_func = op;
                    state_d  = S_T3;
                end
            end
            S_T3: begin
                G_out   = 1'b1;
                R_in    = rx_oh;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
